sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
- Command-path sequencer directly downstream of the Wishbone register file (sd_controller_wb).
- Consumes cmd_start, the argument register, the command register, cmd_timeout_reg, software reset and cmd_int_rst from the register file.
- Drives a 40-bit command frame and a start strobe to the serial command PHY, supervises the command timeout, and unpacks the PHY response.
- Returns response_0..3 and cmd_int_status back to the register file.

Parameters:
- CMD_TIMEOUT_W, 24: width of the timeout count and timeout register.
- CMD_REG_SIZE, 14: width of command_reg.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- software_reset_i  in  1  synchronous soft reset, active-high level.
- cmd_start_i  in  1  one-cycle start pulse from the register file.
- argument_i  in  32  command argument.
- command_i  in  CMD_REG_SIZE  command register, decoded as:
  - [13:8] command index
  - [4] index-check enable
  - [3] CRC-check enable
  - [1:0] response type: 00 none, 01 short, 10 long, 11 short
- timeout_i  in  CMD_TIMEOUT_W  timeout in clock cycles; 0 disables the timeout.
- int_rst_i  in  1  pulse that clears int_status_o.
- cmd_o  out  40  frame to PHY: {2'b01, index[5:0], argument[31:0]}.
- start_xfr_o  out  1  one-cycle transfer strobe to PHY.
- with_response_o  out  1  response expected.
- long_response_o  out  1  136-bit response expected.
- go_idle_o  out  1  one-cycle PHY abort pulse.
- finish_i  in  1  PHY transfer-complete pulse.
- crc_ok_i  in  1  response CRC valid; sampled with finish_i.
- index_ok_i  in  1  response index matches; sampled with finish_i.
- response_i  in  120  PHY response payload, MSB-first.
- response_0_o .. response_3_o  out  32 each  unpacked response words.
- int_status_o  out  5  status bits:
  - [0] CC, command complete
  - [1] EI, error
  - [2] CTE, timeout
  - [3] CCRCE, CRC error
  - [4] CIE, index error
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, wb_rst_n_i=0): state IDLE; every output and register is 0, including cmd_o, response_0..3_o, int_status_o and the timeout counter.
- software_reset_i=1: same effect as reset, applied on the clock edge. If the state was not IDLE, go_idle_o pulses for 1 cycle.
- IDLE state:
  - cmd_start_i=1 latches argument_i and command_i, then moves to SETUP.
  - cmd_start_i is ignored in every other state; no status is raised.
- SETUP state (1 cycle):
  - cmd_o is driven from the latched values.
  - with_response_o = |type; long_response_o = (type==10). Both hold until the next command.
  - start_xfr_o=1 for this cycle only.
  - Timeout counter cleared; next state EXECUTE.
  - Latency: start_xfr_o asserts 2 cycles after the cmd_start_i edge.
- EXECUTE state:
  - The counter increments by 1 each cycle.
  - Timeout: when timeout_i!=0 and counter==timeout_i, set CTE and EI, pulse go_idle_o, go to IDLE. CC is not set. Responses are unchanged.
  - finish_i=1: CC is set.
    - CCRCE and EI are set if CRC check is enabled and crc_ok_i=0.
    - CIE and EI are set if index check is enabled and index_ok_i=0.
    - Go to IDLE.
  - finish_i and timeout in the same cycle: finish wins and no CTE is raised.
- Response unpack, registered on the finish_i cycle:
  - short: response_0 = response_i[119:88]; response_1..3 unchanged.
  - long: response_0 = [119:88], response_1 = [87:56], response_2 = [55:24], response_3 = {[23:0], 8'h00}.
  - none: response words unchanged.
- Status bits are sticky OR; they are cleared only by int_rst_i, reset or software reset.
- int_rst_i in the same cycle as a new status set: the cleared value is ORed with the new bits, so the new bits survive.
- Counter saturates at all-ones and never wraps.
- timeout_i changing mid-command takes effect immediately.

Test Plan:
- Reset, then cmd_start with argument 0x01020304 and command 0x1119 (index 17, CRC+index check, short). Expected: start_xfr_o pulses 2 cycles later; cmd_o = 0x5101020304; busy_o=1.
- Then finish_i with crc_ok=1, index_ok=1, response_i[119:88]=0x00000900. Expected: response_0_o=0x00000900; int_status_o=0x01; busy_o=0 next cycle.
- Long command (type 10) with response_i = 120'h0102..78, then int_rst_i. Expected: response_0..3 unpack per the mapping with 8'h00 low padding; int_status_o returns to 0.
- timeout_i=10 and no finish_i. Expected: int_status_o=0x06 at 10 cycles into EXECUTE; go_idle_o pulses once; response words unchanged.
- finish_i with crc_ok_i=0 and CRC check on. Expected: int_status_o=0x0B. Then int_rst_i coincident with a new completion: int_status_o=0x01.
- cmd_start_i while busy is ignored. Separately, software_reset_i during EXECUTE: go_idle_o pulses, state returns to IDLE, all outputs are 0.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
//   Command-path sequencer between the Wishbone register file and the serial
//   command PHY. Latches a command on cmd_start_i, presents the 40-bit frame
//   and a one-cycle start strobe to the PHY, supervises the command timeout
//   and unpacks the PHY response into four 32-bit words plus status bits.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, async active-low reset
//   software_reset_i       synchronous soft reset (aborts an active command)
//   cmd_start_i            one-cycle start pulse, honoured only when idle
//   argument_i, command_i  command argument / command register
//   timeout_i              timeout in cycles, 0 disables
//   int_rst_i              clears int_status_o
//   cmd_o, start_xfr_o, with_response_o, long_response_o, go_idle_o   to PHY
//   finish_i, crc_ok_i, index_ok_i, response_i                         from PHY
//   response_0_o..response_3_o, int_status_o                           to regs
//   busy_o                 high while a command is in flight
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for cmd_start_i
// SETUP   | one cycle: frame, response flags and start strobe registered
// EXECUTE | waiting for finish_i or timeout; counter running
module sd_cmd_sequencer #(
  parameter int CMD_TIMEOUT_W = 24,
  parameter int CMD_REG_SIZE  = 14
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     software_reset_i,
  input  logic                     cmd_start_i,
  input  logic [31:0]              argument_i,
  input  logic [CMD_REG_SIZE-1:0]  command_i,
  input  logic [CMD_TIMEOUT_W-1:0] timeout_i,
  input  logic                     int_rst_i,
  output logic [39:0]              cmd_o,
  output logic                     start_xfr_o,
  output logic                     with_response_o,
  output logic                     long_response_o,
  output logic                     go_idle_o,
  input  logic                     finish_i,
  input  logic                     crc_ok_i,
  input  logic                     index_ok_i,
  input  logic [119:0]             response_i,
  output logic [31:0]              response_0_o,
  output logic [31:0]              response_1_o,
  output logic [31:0]              response_2_o,
  output logic [31:0]              response_3_o,
  output logic [4:0]               int_status_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    EXECUTE = 2'd2
  } state_t;

  localparam logic [CMD_TIMEOUT_W-1:0] CNT_ONE = 1;

  state_t                   state_q, state_d;
  logic                     latch_cmd, do_setup, do_timeout, do_finish;
  logic [4:0]               status_set;

  logic [31:0]              arg_q;
  logic [5:0]               idx_q;
  logic                     idx_en_q;
  logic                     crc_en_q;
  logic [1:0]               rtype_q;
  logic [CMD_TIMEOUT_W-1:0] count_q;

  // Command register bits with no function in this block.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{command_i[7:5], command_i[2]};

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)           state_q <= IDLE;
    else if (software_reset_i) state_q <= IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    latch_cmd  = 1'b0;
    do_setup   = 1'b0;
    do_timeout = 1'b0;
    do_finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start_i) begin
          latch_cmd = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        do_setup = 1'b1;
        state_d  = EXECUTE;
      end
      EXECUTE: begin
        // finish has priority over a timeout landing in the same cycle
        if (finish_i) begin
          do_finish = 1'b1;
          state_d   = IDLE;
        end else if ((timeout_i != '0) && (count_q == timeout_i)) begin
          do_timeout = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status bits: {CIE, CCRCE, CTE, EI, CC}
  always_comb begin
    status_set = 5'b0;
    if (do_finish) begin
      status_set[0] = 1'b1;
      status_set[3] = crc_en_q & ~crc_ok_i;
      status_set[4] = idx_en_q & ~index_ok_i;
      status_set[1] = status_set[3] | status_set[4];
    end else if (do_timeout) begin
      status_set = 5'b00110;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      arg_q           <= '0;
      idx_q           <= '0;
      idx_en_q        <= 1'b0;
      crc_en_q        <= 1'b0;
      rtype_q         <= '0;
      count_q         <= '0;
      cmd_o           <= '0;
      start_xfr_o     <= 1'b0;
      with_response_o <= 1'b0;
      long_response_o <= 1'b0;
      go_idle_o       <= 1'b0;
      response_0_o    <= '0;
      response_1_o    <= '0;
      response_2_o    <= '0;
      response_3_o    <= '0;
      int_status_o    <= '0;
    end else if (software_reset_i) begin
      arg_q           <= '0;
      idx_q           <= '0;
      idx_en_q        <= 1'b0;
      crc_en_q        <= 1'b0;
      rtype_q         <= '0;
      count_q         <= '0;
      cmd_o           <= '0;
      start_xfr_o     <= 1'b0;
      with_response_o <= 1'b0;
      long_response_o <= 1'b0;
      // tell the PHY to abandon whatever it was doing
      go_idle_o       <= (state_q != IDLE);
      response_0_o    <= '0;
      response_1_o    <= '0;
      response_2_o    <= '0;
      response_3_o    <= '0;
      int_status_o    <= '0;
    end else begin
      start_xfr_o <= do_setup;
      go_idle_o   <= do_timeout;

      if (latch_cmd) begin
        arg_q    <= argument_i;
        idx_q    <= command_i[13:8];
        idx_en_q <= command_i[4];
        crc_en_q <= command_i[3];
        rtype_q  <= command_i[1:0];
      end

      if (do_setup) begin
        cmd_o           <= {2'b01, idx_q, arg_q};
        with_response_o <= |rtype_q;
        long_response_o <= (rtype_q == 2'b10);
        count_q         <= '0;
      end else if ((state_q == EXECUTE) && !(&count_q)) begin
        count_q <= count_q + CNT_ONE;
      end

      if (do_finish) begin
        case (rtype_q)
          2'b10: begin
            response_0_o <= response_i[119:88];
            response_1_o <= response_i[87:56];
            response_2_o <= response_i[55:24];
            response_3_o <= {response_i[23:0], 8'h00};
          end
          2'b01, 2'b11: response_0_o <= response_i[119:88];
          default: ;
        endcase
      end

      // new bits survive a coincident clear
      int_status_o <= (int_rst_i ? 5'b0 : int_status_o) | status_set;
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer. Stimulus tasks keep a
// transaction-level picture of what every output must be after each clock
// edge; a single compare process checks all outputs on every falling edge.
module tb_sd_cmd_sequencer;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_n_i = 1'b1;
  logic          software_reset_i = 1'b0;
  logic          cmd_start_i = 1'b0;
  logic [31:0]   argument_i = '0;
  logic [13:0]   command_i = '0;
  logic [23:0]   timeout_i = '0;
  logic          int_rst_i = 1'b0;
  logic [39:0]   cmd_o;
  logic          start_xfr_o, with_response_o, long_response_o, go_idle_o;
  logic          finish_i = 1'b0;
  logic          crc_ok_i = 1'b1;
  logic          index_ok_i = 1'b1;
  logic [119:0]  response_i = '0;
  logic [31:0]   response_0_o, response_1_o, response_2_o, response_3_o;
  logic [4:0]    int_status_o;
  logic          busy_o;

  sd_cmd_sequencer #(.CMD_TIMEOUT_W(24), .CMD_REG_SIZE(14)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .software_reset_i(software_reset_i), .cmd_start_i(cmd_start_i),
    .argument_i(argument_i), .command_i(command_i), .timeout_i(timeout_i),
    .int_rst_i(int_rst_i), .cmd_o(cmd_o), .start_xfr_o(start_xfr_o),
    .with_response_o(with_response_o), .long_response_o(long_response_o),
    .go_idle_o(go_idle_o), .finish_i(finish_i), .crc_ok_i(crc_ok_i),
    .index_ok_i(index_ok_i), .response_i(response_i),
    .response_0_o(response_0_o), .response_1_o(response_1_o),
    .response_2_o(response_2_o), .response_3_o(response_3_o),
    .int_status_o(int_status_o), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // expected outputs
  logic [39:0] e_cmd = '0;
  logic        e_start = 1'b0, e_with = 1'b0, e_long = 1'b0;
  logic        e_goidle = 1'b0, e_busy = 1'b0;
  logic [31:0] e_resp [4] = '{default: '0};
  logic [4:0]  e_status = '0;

  // command in flight, as seen by the model
  logic [13:0] cur_cmd = '0;
  logic [23:0] exec_n = '0;
  bit          in_exec = 1'b0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      chk("cmd_o", cmd_o, e_cmd);
      chk("start_xfr_o", start_xfr_o, e_start);
      chk("with_response_o", with_response_o, e_with);
      chk("long_response_o", long_response_o, e_long);
      chk("go_idle_o", go_idle_o, e_goidle);
      chk("busy_o", busy_o, e_busy);
      chk("response_0_o", response_0_o, e_resp[0]);
      chk("response_1_o", response_1_o, e_resp[1]);
      chk("response_2_o", response_2_o, e_resp[2]);
      chk("response_3_o", response_3_o, e_resp[3]);
      chk("int_status_o", int_status_o, e_status);
    end
  end

  // advance one clock edge; pulses default to low afterwards
  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
    e_start  = 1'b0;
    e_goidle = 1'b0;
  endtask

  task automatic start_cmd(input logic [31:0] arg, input logic [13:0] cmd);
    cmd_start_i = 1'b1;
    argument_i  = arg;
    command_i   = cmd;
    cyc();
    cmd_start_i = 1'b0;
    argument_i  = ~arg;   // the frame must come from latched values
    command_i   = ~cmd;
    e_busy = 1'b1;
    cyc();
    cur_cmd = cmd;
    e_cmd   = {2'b01, cmd[13:8], arg};
    e_start = 1'b1;
    e_with  = |cmd[1:0];
    e_long  = (cmd[1:0] == 2'b10);
    exec_n  = '0;
    in_exec = 1'b1;
  endtask

  // one executing cycle with no finish: timeout fires at the edge where the
  // cycles spent in EXECUTE equal a non-zero timeout
  task automatic tick();
    logic fire;
    fire = (timeout_i != 24'd0) && (exec_n == timeout_i);
    cyc();
    if (fire) begin
      e_busy   = 1'b0;
      e_goidle = 1'b1;
      e_status = e_status | 5'h06;
      in_exec  = 1'b0;
    end else if (exec_n != 24'hFFFFFF) begin
      exec_n = exec_n + 24'd1;
    end
  endtask

  task automatic finish_cmd(input logic crc, input logic idx,
                            input logic [119:0] resp, input logic irst);
    logic crce, cie;
    finish_i   = 1'b1;
    crc_ok_i   = crc;
    index_ok_i = idx;
    response_i = resp;
    int_rst_i  = irst;
    cyc();
    finish_i   = 1'b0;
    int_rst_i  = 1'b0;
    crc_ok_i   = 1'b1;
    index_ok_i = 1'b1;
    crce = cur_cmd[3] & ~crc;
    cie  = cur_cmd[4] & ~idx;
    e_status = (irst ? 5'h00 : e_status) | {cie, crce, 1'b0, crce | cie, 1'b1};
    if (cur_cmd[1:0] == 2'b10) begin
      e_resp[0] = resp[119:88];
      e_resp[1] = resp[87:56];
      e_resp[2] = resp[55:24];
      e_resp[3] = {resp[23:0], 8'h00};
    end else if (cur_cmd[1:0] != 2'b00) begin
      e_resp[0] = resp[119:88];
    end
    e_busy  = 1'b0;
    in_exec = 1'b0;
  endtask

  task automatic clr_int();
    int_rst_i = 1'b1;
    cyc();
    int_rst_i = 1'b0;
    e_status  = 5'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 wb_rst_n_i = 1'b0;
    #1;
    chk("rst_cmd_o", cmd_o, 40'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_status", int_status_o, 5'h00);
    chk("rst_resp0", response_0_o, 32'h0);
    chk("rst_start", start_xfr_o, 1'b0);
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    #1 wb_rst_n_i = 1'b1;
    chk_en = 1'b1;
    cyc();
    cyc();

    // short command with CRC and index checks, clean completion
    start_cmd(32'h01020304, 14'h1119);
    chk("t1_cmd_o", cmd_o, 40'h5101020304);
    chk("t1_start", start_xfr_o, 1'b1);
    chk("t1_busy", busy_o, 1'b1);
    tick(); tick(); tick();
    finish_cmd(1'b1, 1'b1, {32'h00000900, 88'h0}, 1'b0);
    chk("t1_resp0", response_0_o, 32'h00000900);
    chk("t1_status", int_status_o, 5'h01);
    chk("t1_idle", busy_o, 1'b0);
    cyc();

    // long response unpack, then clear status
    start_cmd(32'hAABBCCDD, 14'h0202);
    chk("t2_long", long_response_o, 1'b1);
    tick();
    finish_cmd(1'b1, 1'b1, 120'h112233445566778899AABBCCDDEEFF, 1'b0);
    chk("t2_resp0", response_0_o, 32'h11223344);
    chk("t2_resp1", response_1_o, 32'h55667788);
    chk("t2_resp2", response_2_o, 32'h99AABBCC);
    chk("t2_resp3", response_3_o, 32'hDDEEFF00);
    clr_int();
    chk("t2_status_clr", int_status_o, 5'h00);

    // timeout of 10 with no finish
    timeout_i = 24'd10;
    start_cmd(32'h00000000, 14'h0501);
    n = 0;
    while (in_exec && n < 50) begin tick(); n++; end
    chk("t3_ticks", n, 11);
    chk("t3_status", int_status_o, 5'h06);
    chk("t3_go_idle", go_idle_o, 1'b1);
    chk("t3_resp3_kept", response_3_o, 32'hDDEEFF00);
    cyc();
    timeout_i = 24'd0;
    clr_int();

    // CRC error, then clear coincident with a new completion
    start_cmd(32'h12345678, 14'h0919);
    tick(); tick();
    finish_cmd(1'b0, 1'b1, {32'hCAFEF00D, 88'h0}, 1'b0);
    chk("t4_status_crc", int_status_o, 5'h0B);
    start_cmd(32'h00000001, 14'h0919);
    tick();
    finish_cmd(1'b1, 1'b1, {32'h0BADBEEF, 88'h0}, 1'b1);
    chk("t4_status_rst_new", int_status_o, 5'h01);

    // index error
    start_cmd(32'h00000002, 14'h0919);
    finish_cmd(1'b1, 1'b0, {32'h13572468, 88'h0}, 1'b0);
    chk("t5_status_idx", int_status_o, 5'h13);
    clr_int();

    // finish in the same cycle the timeout would fire; no-response type
    timeout_i = 24'd4;
    start_cmd(32'h00000055, 14'h0300);
    chk("t6_with", with_response_o, 1'b0);
    tick(); tick(); tick(); tick();
    finish_cmd(1'b1, 1'b1, {32'hFFFFFFFF, 88'h0}, 1'b0);
    chk("t6_status", int_status_o, 5'h01);
    chk("t6_go_idle", go_idle_o, 1'b0);
    chk("t6_resp0_kept", response_0_o, 32'h13572468);
    clr_int();

    // timeout register changed while executing
    timeout_i = 24'd100;
    start_cmd(32'h00000077, 14'h0401);
    tick(); tick(); tick();
    timeout_i = 24'd6;
    n = 0;
    while (in_exec && n < 50) begin tick(); n++; end
    chk("t7_ticks", n, 4);
    chk("t7_status", int_status_o, 5'h06);
    cyc();
    timeout_i = 24'd0;
    clr_int();

    // start while busy is ignored
    start_cmd(32'hA5A5A5A5, 14'h0A01);
    cmd_start_i = 1'b1;
    argument_i  = 32'hDEADBEEF;
    command_i   = 14'h3F02;
    tick();
    cmd_start_i = 1'b0;
    tick(); tick();
    chk("t8_cmd_o", cmd_o, 40'h4AA5A5A5A5);
    finish_cmd(1'b1, 1'b1, {32'h76543210, 88'h0}, 1'b0);
    cyc(); cyc(); cyc();
    chk("t8_status", int_status_o, 5'h01);
    chk("t8_idle", busy_o, 1'b0);

    // software reset during EXECUTE, then while idle
    start_cmd(32'h0F0F0F0F, 14'h0702);
    tick(); tick();
    software_reset_i = 1'b1;
    cyc();
    software_reset_i = 1'b0;
    e_cmd = '0; e_with = 1'b0; e_long = 1'b0; e_busy = 1'b0;
    e_resp = '{default: '0}; e_status = 5'h00;
    e_goidle = 1'b1; in_exec = 1'b0;
    chk("t9_go_idle", go_idle_o, 1'b1);
    chk("t9_busy", busy_o, 1'b0);
    chk("t9_cmd_o", cmd_o, 40'h0);
    chk("t9_resp0", response_0_o, 32'h0);
    cyc();
    software_reset_i = 1'b1;
    cyc();
    software_reset_i = 1'b0;
    chk("t9_idle_no_go_idle", go_idle_o, 1'b0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
